wb_rr_arbiter: RTL and testbench

//  Round-robin Wishbone arbiter: shares one classic-cycle slave (e.g. console UART) among N masters.

---
 rtl/wb_rr_arbiter_if.sv | 36 +++
 rtl/wb_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and one shared slave.
// The arbiter connects through the slave modport; the surrounding masters and slave use the master modport.
interface wb_rr_arbiter_if #(
  parameter int N  = 3,
  parameter int AW = 2,
  parameter int DW = 32
);
  localparam int COLS = DW / 8;

  logic [N-1:0]      m_cyc_i;
  logic [N-1:0]      m_stb_i;
  logic [N-1:0]      m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*COLS-1:0] m_sel_i;
  logic [N-1:0]      m_ack_o;
  logic [DW-1:0]     m_dat_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [COLS-1:0]   s_sel_o;
  logic              s_ack_i;
  logic [DW-1:0]     s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic-cycle arbiter: N masters share one slave, grant held for a whole cyc burst.
// Optional WB_ARB_TIMEOUT_EN adds a stuck-slave watchdog (TIMEOUT parameter, sticky to_o output).
module wb_rr_arbiter #(
  parameter int N  = 3,
  parameter int AW = 2,
  parameter int DW = 32
`ifdef WB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic          clk,
  input  logic          rst,
  wb_rr_arbiter_if.slave bus,
  output logic [N-1:0]  gnt_o
`ifdef WB_ARB_TIMEOUT_EN
  , output logic        to_o
`endif
);
  localparam int COLS = DW / 8;
  localparam int IW   = $clog2(N);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick_idx_s;
  logic          pick_found_s;
  logic          own_cyc_s;
  logic          own_stb_s;
  logic          fire_s;

  assign own_cyc_s = bus.m_cyc_i[idx_q];
  assign own_stb_s = bus.m_stb_i[idx_q];
  assign gnt_o     = gnt_q;

  // First requester found when scanning upward from the priority pointer, wrapping at N.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!pick_found_s && bus.m_cyc_i[(int'(ptr_q) + i) % N]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'((int'(ptr_q) + i) % N);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          to_q;

  // The watchdog fires only on a live strobe, so a release cycle never gets a fake ack.
  assign fire_s = (state_q == BUSY) && !rst && own_cyc_s && own_stb_s && !bus.s_ack_i &&
                  (wd_q == TW'(TIMEOUT - 1));
  assign to_o   = to_q;

  // Count strobe cycles without an ack; any ack, release, idle or timeout restarts the count.
  always_comb begin
    wd_d = wd_q;
    if ((state_q != BUSY) || !own_cyc_s || bus.s_ack_i || fire_s) begin
      wd_d = {TW{1'b0}};
    end else if (own_stb_s) begin
      wd_d = wd_q + TW'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= {TW{1'b0}};
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_q | fire_s;
    end
  end
`else
  assign fire_s = 1'b0;
`endif

  // Arbitration FSM next state: grant registered from IDLE, released when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = BUSY;
          idx_d   = pick_idx_s;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!own_cyc_s) begin
          state_d = IDLE;
          gnt_d   = {N{1'b0}};
          ptr_d   = (idx_q == IW'(N - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N{1'b0}};
      end
    endcase
  end

  // Bus steering; reset drops cyc/stb/ack in the same cycle it is asserted.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.m_ack_o = {N{1'b0}};
    bus.m_dat_o = bus.s_dat_i;
    bus.s_we_o  = bus.m_we_i[idx_q];
    bus.s_adr_o = bus.m_adr_i[int'(idx_q) * AW +: AW];
    bus.s_dat_o = bus.m_dat_i[int'(idx_q) * DW +: DW];
    bus.s_sel_o = bus.m_sel_i[int'(idx_q) * COLS +: COLS];
    if ((state_q == BUSY) && !rst) begin
      bus.s_cyc_o        = own_cyc_s;
      bus.s_stb_o        = own_stb_s & ~fire_s;
      bus.m_ack_o[idx_q] = own_cyc_s & (bus.s_ack_i | fire_s);
    end else begin
      bus.s_cyc_o = 1'b0;
    end
    if (fire_s) begin
      bus.m_dat_o = {DW{1'b0}};
    end else begin
      bus.m_dat_o = bus.s_dat_i;
    end
  end

  // State, grant, owner index and priority pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= {N{1'b0}};
      idx_q   <= {IW{1'b0}};
      ptr_q   <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed table, hand sequences, random traffic vs. a reference model.
module tb_wb_rr_arbiter;
  localparam int N = 3, AW = 2, DW = 32, COLS = 4, TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] gnt_o;
`ifdef WB_ARB_TIMEOUT_EN
  logic         to_o;
`endif

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(
    .N(N), .AW(AW), .DW(DW)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .gnt_o(gnt_o)
`ifdef WB_ARB_TIMEOUT_EN
    , .to_o(to_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 = bus free), rotating start point, watchdog count.
  int own = -1;
  int ptr = 0;
  int wd  = 0;
  bit to_exp = 1'b0;

  typedef struct {
    bit       rst;
    bit [2:0] cyc;
    bit       ack;
    bit [2:0] e_gnt;
    bit [2:0] e_ack;
    bit       e_cyc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int scan();
    for (int i = 0; i < N; i++) begin
      if (bus.m_cyc_i[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic bit fire_now();
`ifdef WB_ARB_TIMEOUT_EN
    if (own < 0 || rst) return 1'b0;
    return bus.m_cyc_i[own] && bus.m_stb_i[own] && !bus.s_ack_i && (wd == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_check();
    logic [N-1:0] e_gnt, e_ack;
    logic e_cyc, e_stb;
    bit f;
    f = fire_now();
    e_gnt = '0; e_ack = '0; e_cyc = 1'b0; e_stb = 1'b0;
    if (own >= 0) e_gnt[own] = 1'b1;
    if (own >= 0 && !rst) begin
      e_cyc = bus.m_cyc_i[own];
      e_stb = bus.m_stb_i[own] && !f;
      if (bus.m_cyc_i[own] && (bus.s_ack_i || f)) e_ack[own] = 1'b1;
    end
    chk("gnt", gnt_o, e_gnt);
    chk("s_cyc", bus.s_cyc_o, e_cyc);
    chk("s_stb", bus.s_stb_o, e_stb);
    chk("m_ack", bus.m_ack_o, e_ack);
    chk("m_dat", bus.m_dat_o, f ? 32'h0 : bus.s_dat_i);
    if (own >= 0 && !rst) begin
      chk("s_we", bus.s_we_o, bus.m_we_i[own]);
      chk("s_adr", bus.s_adr_o, bus.m_adr_i[own*AW +: AW]);
      chk("s_dat", bus.s_dat_o, bus.m_dat_i[own*DW +: DW]);
      chk("s_sel", bus.s_sel_o, bus.m_sel_i[own*COLS +: COLS]);
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("to_o", to_o, to_exp);
`endif
  endtask

  task automatic model_update();
    bit f;
    f = fire_now();
    if (rst) begin
      own = -1; ptr = 0; wd = 0; to_exp = 1'b0;
    end else begin
      if (f) to_exp = 1'b1;
      if (own < 0 || !bus.m_cyc_i[own] || bus.s_ack_i || f) wd = 0;
      else if (bus.m_stb_i[own]) wd++;
      if (own < 0) own = scan();
      else if (!bus.m_cyc_i[own]) begin
        ptr = (own + 1) % N;
        own = -1;
      end
    end
  endtask

  task automatic step();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.s_ack_i = 1'b0; bus.s_dat_i = 32'h0;
  endtask

  task automatic set_master(input int k, input bit c, input bit s, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [COLS-1:0] sl);
    bus.m_cyc_i[k] = c; bus.m_stb_i[k] = s; bus.m_we_i[k] = w;
    bus.m_adr_i[k*AW +: AW] = a; bus.m_dat_i[k*DW +: DW] = d; bus.m_sel_i[k*COLS +: COLS] = sl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl = '{
      '{1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b001, 3'b000, 1'b0},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b110, 1'b1, 3'b010, 3'b010, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b010, 3'b000, 1'b0},
      '{1'b0, 3'b101, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b101, 1'b1, 3'b100, 3'b100, 1'b1},
      '{1'b0, 3'b001, 1'b0, 3'b100, 3'b000, 1'b0},
      '{1'b0, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0},
      '{1'b0, 3'b001, 1'b1, 3'b001, 3'b001, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0}
    };

    rst = 1'b1;
    idle_inputs();
    model_update();
    @(posedge clk);
    #1;

    // Reset, then fair rotation 0,1,2,0 with one idle cycle between owners.
    for (int r = 0; r < 16; r++) begin
      rst = tbl[r].rst;
      bus.m_cyc_i = tbl[r].cyc;
      bus.m_stb_i = tbl[r].cyc;
      bus.s_ack_i = tbl[r].ack;
      #1;
      chk($sformatf("tbl%0d_gnt", r), gnt_o, tbl[r].e_gnt);
      chk($sformatf("tbl%0d_ack", r), bus.m_ack_o, tbl[r].e_ack);
      chk($sformatf("tbl%0d_cyc", r), bus.s_cyc_o, tbl[r].e_cyc);
      chk($sformatf("tbl%0d_stb", r), bus.s_stb_o, tbl[r].e_cyc);
      model_update();
      @(posedge clk);
      #1;
    end

    // Master1 write, slave acks one cycle after the grant.
    idle_inputs();
    set_master(1, 1'b1, 1'b1, 1'b1, 2'd2, 32'hA500_0000, 4'hF);
    #1; chk("wr_gnt_wait", gnt_o, 3'b000); step();
    #1; chk("wr_gnt", gnt_o, 3'b010); chk("wr_sdat", bus.s_dat_o, 32'hA500_0000);
    chk("wr_adr", bus.s_adr_o, 2'd2); chk("wr_we", bus.s_we_o, 1'b1);
    chk("wr_sel", bus.s_sel_o, 4'hF); chk("wr_noack", bus.m_ack_o, 3'b000); step();
    bus.s_ack_i = 1'b1;
    #1; chk("wr_ack", bus.m_ack_o, 3'b010); step();
    set_master(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    bus.s_ack_i = 1'b0;
    #1; chk("wr_ack_gone", bus.m_ack_o, 3'b000); step();

    // Master2 read returns slave data.
    set_master(2, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
    bus.s_dat_i = 32'h1234_5678;
    #1; step();
    bus.s_ack_i = 1'b1;
    #1; chk("rd_mdat", bus.m_dat_o, 32'h1234_5678); chk("rd_ack", bus.m_ack_o, 3'b100); step();
    set_master(2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    bus.s_ack_i = 1'b0;
    #1; step();

    // Master0 burst of three acked strobes while master2 waits.
    set_master(0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 4'h1);
    set_master(2, 1'b1, 1'b1, 1'b1, 2'd0, 32'hCAFE_0002, 4'h3);
    #1; step();
    bus.s_ack_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1; chk("burst_gnt", gnt_o, 3'b001); chk("burst_ack", bus.m_ack_o, 3'b001); step();
    end
    set_master(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    #1; chk("burst_rel_ack", bus.m_ack_o, 3'b000); step();
    bus.s_ack_i = 1'b0;
    #1; chk("burst_gap", gnt_o, 3'b000); chk("burst_wait_ack", bus.m_ack_o, 3'b000); step();
    #1; chk("burst_next_gnt", gnt_o, 3'b100); chk("burst_next_dat", bus.s_dat_o, 32'hCAFE_0002); step();
    idle_inputs();
    #1; step();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: forced ack on the 16th strobe cycle, sticky flag, then next master proceeds.
    begin
      bit seen;
      int busy;
      seen = 1'b0; busy = 0;
      rst = 1'b1; #1; step(); rst = 1'b0;
      set_master(1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
      bus.s_dat_i = 32'hDEAD_BEEF;
      for (int c = 0; c < 40 && !seen; c++) begin
        #1;
        if (bus.m_ack_o[1]) begin
          seen = 1'b1;
          chk("to_mdat", bus.m_dat_o, 32'h0);
          chk("to_stb", bus.s_stb_o, 1'b0);
          chk("to_cycles", busy + 1, 16);
        end else if (gnt_o == 3'b010) begin
          busy++;
        end
        step();
      end
      chk("to_seen", seen, 1'b1);
      chk("to_flag", to_o, 1'b1);
      set_master(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
      set_master(2, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 4'hF);
      #1; step();
      #1; step();
      #1; chk("to_next_gnt", gnt_o, 3'b100); chk("to_sticky", to_o, 1'b1); step();
      idle_inputs();
    end
`endif

    // Random traffic with sticky requests and occasional resets, checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(63) == 0);
      for (int k = 0; k < N; k++) begin
        if (bus.m_cyc_i[k]) bus.m_cyc_i[k] = ($urandom_range(3) != 0);
        else                bus.m_cyc_i[k] = ($urandom_range(2) == 0);
        bus.m_stb_i[k] = ($urandom_range(3) != 0);
      end
      bus.m_we_i  = N'($urandom);
      bus.m_adr_i = (N*AW)'($urandom);
      bus.m_dat_i = {$urandom, $urandom, $urandom};
      bus.m_sel_i = (N*COLS)'($urandom);
      bus.s_ack_i = ($urandom_range(1) == 0);
      bus.s_dat_i = $urandom;
      #1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
